// File: rtl/mul_bus_sequencer.sv
// Bus-master front end for the GPIO multiplier: buffers 24x24 operand pairs, drives the
// peripheral register map per pair and streams results out. `MULSEQ_ONES_CHECK_EN adds a popcount self-check.
module mul_bus_sequencer #(
  parameter int unsigned IN_DEPTH   = 4,
  parameter int unsigned OUT_DEPTH  = 4,
  parameter int unsigned STB_CYCLES = 2,
  parameter int unsigned POLL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [23:0] op_a,
  input  logic [23:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [5:0]  res_ones,
  output logic        res_ovf,
  output logic        res_tmo,
  output logic        res_chk_err,
  output logic [15:0] m_saddress,
  output logic        m_swr,
  output logic        m_srd,
  output logic [31:0] m_sdata_out,
  input  logic [31:0] m_sdata_in,
  output logic        busy,
  output logic [7:0]  err_count
);
  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned PHW = $clog2(STB_CYCLES + 1);
  localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [IAW:0]   IN_FULL  = (IAW + 1)'(IN_DEPTH);
  localparam logic [OAW:0]   OUT_FULL = (OAW + 1)'(OUT_DEPTH);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(STB_CYCLES - 1);
  localparam logic [PHW-1:0] PH_GAP   = PHW'(STB_CYCLES);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);

  localparam logic [15:0] ADDR_A1  = 16'h0380;
  localparam logic [15:0] ADDR_A2  = 16'h0388;
  localparam logic [15:0] ADDR_CTL = 16'h03A0;
  localparam logic [15:0] ADDR_W   = 16'h0390;
  localparam logic [15:0] ADDR_L   = 16'h0398;

  typedef enum logic [2:0] {IDLE, WR_A1, WR_A2, WR_GO, POLL, RD_W, RD_L, PUSH} state_e;

  state_e         state_q, state_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [23:0]    a_q, a_d, b_q, b_d;
  logic [31:0]    w_q, w_d;
  logic [5:0]     ones_q, ones_d;
  logic           ovf_q, ovf_d, tmo_q, tmo_d;
  logic [1:0]     stat_q, stat_d;
  logic [7:0]     err_q, err_d;
  logic           chk_err;

  // Operand FIFO
  logic [47:0]    in_mem_q [IN_DEPTH];
  logic [IAW-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [IAW:0]   in_cnt_q, in_cnt_d;
  logic           op_ready_q, op_ready_d;
  logic           in_push, in_pop;
  logic [47:0]    in_head;

  // Result FIFO entry: {w, ones, ovf, tmo, chk_err}
  logic [40:0]    out_mem_q [OUT_DEPTH];
  logic [OAW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [OAW:0]   out_cnt_q, out_cnt_d;
  logic           out_push, out_pop, out_full;

  assign in_push   = op_valid && op_ready_q;
  assign in_head   = in_mem_q[in_rptr_q];
  assign out_full  = (out_cnt_q == OUT_FULL);
  assign res_valid = (out_cnt_q != '0);
  assign out_pop   = res_valid && res_ready;
  assign op_ready  = op_ready_q;
  assign busy      = (state_q != IDLE);
  assign err_count = err_q;
  assign {res_w, res_ones, res_ovf, res_tmo, res_chk_err} = out_mem_q[out_rptr_q];

  always_comb begin
    in_wptr_d  = in_wptr_q + IAW'(in_push);
    in_rptr_d  = in_rptr_q + IAW'(in_pop);
    in_cnt_d   = in_cnt_q + (IAW + 1)'(in_push) - (IAW + 1)'(in_pop);
    op_ready_d = (in_cnt_d != IN_FULL);
    out_wptr_d = out_wptr_q + OAW'(out_push);
    out_rptr_d = out_rptr_q + OAW'(out_pop);
    out_cnt_d  = out_cnt_q + (OAW + 1)'(out_push) - (OAW + 1)'(out_pop);
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wptr_q]   <= {op_a, op_b};
    if (out_push) out_mem_q[out_wptr_q] <= {w_q, ones_q, ovf_q, tmo_q, chk_err};
  end

`ifdef MULSEQ_ONES_CHECK_EN
  logic [5:0] w_pop;
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < 32; i++) w_pop = w_pop + 6'(w_q[i]);
  end
  assign chk_err = !tmo_q && (w_pop != ones_q);
`else
  assign chk_err = 1'b0;
`endif

  // Each bus state owns one strobe window (phases 0..STB_CYCLES-1) followed by one gap phase.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    poll_d  = poll_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    stat_d  = stat_q;
    err_d   = err_q;
    in_pop  = 1'b0;
    out_push = 1'b0;

    if (state_q inside {WR_A1, WR_A2, WR_GO, POLL, RD_W, RD_L})
      phase_d = (phase_q == PH_GAP) ? '0 : phase_q + PHW'(1);

    case (state_q)
      IDLE: begin
        if (in_cnt_q != '0) begin
          in_pop  = 1'b1;
          {a_d, b_d} = in_head;
          w_d     = '0;
          ones_d  = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          poll_d  = '0;
          phase_d = '0;
          state_d = WR_A1;
        end
      end
      WR_A1: if (phase_q == PH_GAP) state_d = WR_A2;
      WR_A2: if (phase_q == PH_GAP) state_d = WR_GO;
      WR_GO: if (phase_q == PH_GAP) state_d = POLL;
      POLL: begin
        if (phase_q == PH_LAST) begin
          stat_d = m_sdata_in[1:0];
          poll_d = poll_q + PCW'(1);
        end
        if (phase_q == PH_GAP) begin
          if (stat_q[1]) begin
            ovf_d   = ~stat_q[0];
            state_d = RD_W;
          end else if (poll_q == POLL_MAX) begin
            tmo_d   = 1'b1;
            w_d     = '0;
            ones_d  = '0;
            state_d = PUSH;
          end
        end
      end
      RD_W: begin
        if (phase_q == PH_LAST) w_d = m_sdata_in;
        if (phase_q == PH_GAP) state_d = RD_L;
      end
      RD_L: begin
        if (phase_q == PH_LAST) ones_d = m_sdata_in[5:0];
        if (phase_q == PH_GAP) state_d = PUSH;
      end
      PUSH: begin
        if (!out_full) begin
          out_push = 1'b1;
          if ((tmo_q || chk_err) && err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_saddress  = '0;
    m_sdata_out = '0;
    case (state_q)
      WR_A1: begin
        m_saddress  = ADDR_A1;
        m_sdata_out = {8'h00, a_q};
      end
      WR_A2: begin
        m_saddress  = ADDR_A2;
        m_sdata_out = {8'h00, b_q};
      end
      WR_GO, POLL: m_saddress = ADDR_CTL;
      RD_W:        m_saddress = ADDR_W;
      RD_L:        m_saddress = ADDR_L;
      default:     m_saddress = '0;
    endcase
    m_swr = (phase_q <= PH_LAST) && (state_q inside {WR_A1, WR_A2, WR_GO});
    m_srd = (phase_q <= PH_LAST) && (state_q inside {POLL, RD_W, RD_L});
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      poll_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      w_q        <= '0;
      ones_q     <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      stat_q     <= '0;
      err_q      <= '0;
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_cnt_q   <= '0;
      op_ready_q <= 1'b1;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_q     <= poll_d;
      a_q        <= a_d;
      b_q        <= b_d;
      w_q        <= w_d;
      ones_q     <= ones_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      stat_q     <= stat_d;
      err_q      <= err_d;
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      in_cnt_q   <= in_cnt_d;
      op_ready_q <= op_ready_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_cnt_q  <= out_cnt_d;
    end
  end
endmodule

// File: tb/tb_mul_bus_sequencer.sv
// Testbench for mul_bus_sequencer: multiplier-peripheral slave model, table vectors,
// timeout/back-pressure/reset sequences and randomized traffic against a result model.
module tb_mul_bus_sequencer;
  localparam int unsigned STB  = 2;
  localparam int unsigned PLIM = 16;
  localparam int MODE_OK = 0, MODE_TMO = 1, MODE_BADL = 2;

  logic        clk = 1'b0, n_reset = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
  logic [23:0] op_a = '0, op_b = '0;
  logic        op_ready, res_valid, res_ovf, res_tmo, res_chk_err, m_swr, m_srd, busy;
  logic [31:0] res_w, m_sdata_out, m_sdata_in;
  logic [5:0]  res_ones;
  logic [15:0] m_saddress;
  logic [7:0]  err_count;

  mul_bus_sequencer #(.IN_DEPTH(4), .OUT_DEPTH(4), .STB_CYCLES(STB), .POLL_LIMIT(PLIM)) dut (
    .clk(clk), .n_reset(n_reset), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_w(res_w), .res_ones(res_ones), .res_ovf(res_ovf),
    .res_tmo(res_tmo), .res_chk_err(res_chk_err), .m_saddress(m_saddress), .m_swr(m_swr), .m_srd(m_srd),
    .m_sdata_out(m_sdata_out), .m_sdata_in(m_sdata_in), .busy(busy), .err_count(err_count));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model and bus monitor
  int          mode = MODE_OK;
  logic [23:0] s_a1 = '0, s_a2 = '0;
  logic [47:0] s_prod = '0;
  logic        s_done = 1'b0;
  logic        swr_p = 1'b0, srd_p = 1'b0;
  logic [15:0] hi_addr = '0;
  logic [31:0] hi_data = '0;
  int          hi_len = 0, bus_err = 0, stat_reads = 0;
  logic [48:0] bus_log[$];

  always_comb begin
    case (m_saddress)
      16'h03A0: m_sdata_in = {30'h0, s_done, (s_prod[47:32] == 16'h0)};
      16'h0390: m_sdata_in = s_prod[31:0];
      16'h0398: m_sdata_in = (mode == MODE_BADL) ? 32'd5 : 32'($countones(s_prod[31:0]));
      default:  m_sdata_in = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    if (!n_reset) begin
      swr_p = 1'b0;
      srd_p = 1'b0;
    end else begin
      if (m_swr && m_srd) bus_err++;
      if ((m_swr || m_srd) && !(swr_p || srd_p)) begin
        bus_log.push_back({m_swr, m_saddress, m_swr ? m_sdata_out : 32'h0});
        hi_addr = m_saddress;
        hi_data = m_sdata_out;
        hi_len  = 1;
        if (m_srd && m_saddress == 16'h03A0) stat_reads++;
        if (m_swr) begin
          case (m_saddress)
            16'h0380: begin s_a1 = m_sdata_out[23:0]; s_done = 1'b0; end
            16'h0388: s_a2 = m_sdata_out[23:0];
            16'h03A0: begin s_prod = 48'(s_a1) * 48'(s_a2); s_done = (mode != MODE_TMO); end
            default:  bus_err++;
          endcase
        end
      end else if (m_swr || m_srd) begin
        hi_len++;
        if (m_saddress !== hi_addr || m_sdata_out !== hi_data) bus_err++;
      end else if (swr_p || srd_p) begin
        if (hi_len != int'(STB)) bus_err++;
        if (m_saddress !== hi_addr) bus_err++;
      end
      swr_p = m_swr;
      srd_p = m_srd;
    end
  end

  // Result model: what the consumer must see for a pair under a given peripheral behaviour
  function automatic logic [40:0] model(input logic [23:0] a, input logic [23:0] b, input int md);
    logic [47:0] p;
    logic [31:0] w;
    logic [5:0]  ones;
    logic        chk;
    p = 48'(a) * 48'(b);
    if (md == MODE_TMO) return {32'h0, 6'h0, 1'b0, 1'b1, 1'b0};
    w    = p[31:0];
    ones = (md == MODE_BADL) ? 6'd5 : 6'($countones(w));
    chk  = 1'b0;
`ifdef MULSEQ_ONES_CHECK_EN
    chk = ($countones(w) != int'(ones));
`endif
    return {w, ones, (p[47:32] != 16'h0), 1'b0, chk};
  endfunction

  logic [40:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_op(input logic [23:0] a, input logic [23:0] b, output int acc_cyc);
    logic acc;
    acc = 1'b0;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    for (int n = 0; n < 1000 && !acc; n++) begin
      @(negedge clk);
      if (op_ready) acc = 1'b1;
      @(posedge clk);
    end
    #1 op_valid = 1'b0;
    acc_cyc = cyc;
    check("op_accept", acc, 1);
    if (acc) exp_q.push_back(model(a, b, mode));
  endtask

  task automatic get_result(output logic [40:0] r, output int vcyc);
    logic got;
    got = 1'b0;
    r = '0;
    vcyc = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (res_valid) begin
        got  = 1'b1;
        r    = {res_w, res_ones, res_ovf, res_tmo, res_chk_err};
        vcyc = cyc;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
      end
    end
    check("result_arrives", got, 1);
  endtask

  task automatic check_sb(input string name, input logic [40:0] r);
    check({name, "_sb_depth"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) check(name, r, exp_q.pop_front());
  endtask

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [31:0] w;
    logic [5:0]  ones;
    logic        ovf;
  } vec_t;

  vec_t        tbl[7];
  logic [48:0] exp_bus[6];
  logic [40:0] r;
  int          acc_c, acc_c2, vc, base, lsz, stb_seen, st0;
  logic        got;

  initial begin
    tbl[0] = '{24'd3,       24'd5,       32'd15,         6'd4,  1'b0};
    tbl[1] = '{24'hFFFFFF,  24'hFFFFFF,  32'hFE000001,   6'd8,  1'b1};
    tbl[2] = '{24'd2,       24'd7,       32'd14,         6'd3,  1'b0};
    tbl[3] = '{24'd0,       24'h123456,  32'd0,          6'd0,  1'b0};
    tbl[4] = '{24'h010000,  24'h010000,  32'd0,          6'd0,  1'b1};
    tbl[5] = '{24'h00FFFF,  24'h010001,  32'hFFFFFFFF,   6'd32, 1'b0};
    tbl[6] = '{24'd1,       24'hFFFFFF,  32'h00FFFFFF,   6'd24, 1'b0};
    exp_bus[0] = {1'b1, 16'h0380, 32'd3};
    exp_bus[1] = {1'b1, 16'h0388, 32'd5};
    exp_bus[2] = {1'b1, 16'h03A0, 32'd0};
    exp_bus[3] = {1'b0, 16'h03A0, 32'd0};
    exp_bus[4] = {1'b0, 16'h0390, 32'd0};
    exp_bus[5] = {1'b0, 16'h0398, 32'd0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_op_ready", op_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {m_swr, m_srd}, 0);
    check("rst_addr", m_saddress, 0);
    check("rst_wdata", m_sdata_out, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk) n_reset = 1'b1;
    @(posedge clk) #1;

    // Single pair: bus sequence and pop-to-result latency
    base = bus_log.size();
    push_op(24'd3, 24'd5, acc_c);
    get_result(r, vc);
    check("latency_3x5", vc - acc_c, 20);
    check_sb("res_3x5", r);
    check("bus_len_3x5", bus_log.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < bus_log.size()) check("bus_seq_3x5", bus_log[base + i], exp_bus[i]);

    foreach (tbl[i]) begin
      push_op(tbl[i].a, tbl[i].b, acc_c);
      get_result(r, vc);
      check_sb("tbl_model", r);
      check("tbl_w", r[40:9], tbl[i].w);
      check("tbl_ones", r[8:3], tbl[i].ones);
      check("tbl_ovf", r[2], tbl[i].ovf);
      check("tbl_tmo_chk", r[1:0], 0);
    end

    // Peripheral never completes
    mode = MODE_TMO;
    st0 = stat_reads;
    push_op(24'h000123, 24'h000045, acc_c);
    get_result(r, vc);
    check_sb("tmo_res", r);
    check("tmo_flag", r[1], 1);
    check("tmo_w", r[40:9], 0);
    check("tmo_poll_count", stat_reads - st0, PLIM);
    check("tmo_err_count", err_count, 1);
    mode = MODE_OK;
    push_op(24'd6, 24'd7, acc_c);
    get_result(r, vc);
    check_sb("after_tmo_res", r);
    check("after_tmo_w", r[40:9], 42);

`ifdef MULSEQ_ONES_CHECK_EN
    mode = MODE_BADL;
    push_op(24'd3, 24'd5, acc_c);
    get_result(r, vc);
    check_sb("badl_res", r);
    check("badl_chk_err", r[0], 1);
    check("badl_err_count", err_count, 2);
    mode = MODE_OK;
`endif

    // Back-pressure: consumer stalled while ten pairs are offered
    fork
      begin
        for (int k = 0; k < 10; k++) push_op(24'(k * 3 + 1), 24'(k + 2), acc_c2);
      end
      begin
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("bp_res_valid", res_valid, 1);
        check("bp_op_ready", op_ready, 0);
        check("bp_busy", busy, 1);
        lsz = bus_log.size();
        stb_seen = 0;
        repeat (20) begin
          @(negedge clk);
          if (m_swr || m_srd) stb_seen++;
        end
        check("bp_strobes_low", stb_seen, 0);
        check("bp_no_bus_cycles", bus_log.size(), lsz);
        for (int k = 0; k < 10; k++) begin
          get_result(r, vc);
          check_sb("bp_order", r);
        end
      end
    join

    // Randomized traffic with random consumer stalls
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [23:0] ra, rb;
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
          end
          ra = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 32'hFFFF));
          rb = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 32'hFFFF));
          push_op(ra, rb, acc_c2);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 30)) @(negedge clk);
          get_result(r, vc);
          check_sb("rand_res", r);
        end
      end
    join

    // Reset while polling
    mode = MODE_TMO;
    push_op(24'd3, 24'd5, acc_c);
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (m_srd && m_saddress == 16'h03A0) got = 1'b1;
    end
    check("reach_poll", got, 1);
    #2 n_reset = 1'b0;
    #1;
    check("rst_poll_srd", m_srd, 0);
    check("rst_poll_swr", m_swr, 0);
    check("rst_poll_res_valid", res_valid, 0);
    check("rst_poll_busy", busy, 0);
    check("rst_poll_err_count", err_count, 0);
    exp_q.delete();
    mode = MODE_OK;
    @(negedge clk);
    #2 n_reset = 1'b1;
    @(posedge clk) #1;
    check("post_rst_op_ready", op_ready, 1);
    push_op(24'd2, 24'd7, acc_c);
    get_result(r, vc);
    check_sb("post_rst_res", r);
    check("post_rst_w", r[40:9], 14);

    check("bus_protocol_errors", bus_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
    $fatal(1);
  end
endmodule
